// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, inst} with a dominant flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop  && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: credit-limited word fetches, in-order response
// tracking, prefetch buffering and redirect squash.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW:0]   credits_used;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Every issued request owns a queue slot until it is popped or squashed.
  assign credits_used  = {1'b0, in_flight} + {1'b0, count};
  assign mem_req_valid = !redirect_valid && (credits_used < DEPTH_C);
  assign mem_addr      = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_keep   = mem_rsp_valid && (discard == '0);
  assign push_entry = '{pc: rsp_pc, inst: mem_rsp_data};
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      discard   <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle belongs to the old stream too.
      fetch_pc  <= word_align(redirect_pc);
      rsp_pc    <= word_align(redirect_pc);
      in_flight <= in_flight - CW'(mem_rsp_valid);
      discard   <= in_flight - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      in_flight <= in_flight + CW'(req_fire) - CW'(mem_rsp_valid);
      if (mem_rsp_valid) begin
        if (discard != '0) discard <= discard - CW'(1);
        else               rsp_pc  <= rsp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (rsp_keep),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: in-order memory model with configurable
// latency, stream-level reference model, directed scenarios.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        mem_req_ready  = 1'b0;
  logic        mem_rsp_valid  = 1'b0;
  logic [31:0] mem_rsp_data   = 32'h0;
  logic        inst_ready     = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory requests carry the model PC, the address the DUT asked for, the
  // stream epoch they were issued in, and the cycle they are due back.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  req_t        r;
  int          cyc      = 0;
  int          lat      = 1;
  int          epoch    = 0;
  int          hs_total = 0;
  logic [31:0] exp_addr = RPC;
  logic        rsp_now  = 1'b0;
  logic        exp_req;
  logic        have_last = 1'b0;
  logic [31:0] last_pc   = 32'h0;

  // Memory model and reference model: drive responses at the falling edge,
  // compare and advance just before the rising edge.
  always begin
    @(negedge clk);
    cyc++;
    rsp_now = 1'b0;
    if (rst_n && pend.size() != 0) rsp_now = (pend[0].due <= cyc);
    mem_rsp_valid = rsp_now;
    mem_rsp_data  = 32'h0;
    if (rsp_now) mem_rsp_data = pend[0].addr;
    #4;
    if (!rst_n) begin
      check("mon_rst_req_valid", mem_req_valid, 1);
      check("mon_rst_addr", mem_addr, RPC);
      check("mon_rst_inst_valid", inst_valid, 0);
      check("mon_rst_inst", inst, 0);
      check("mon_rst_inst_pc", inst_pc, 0);
      pend.delete();
      mq.delete();
      exp_addr  = RPC;
      have_last = 1'b0;
      epoch++;
    end else begin
      exp_req = !redirect_valid && (pend.size() + mq.size() < DEPTH);
      check("mon_req_valid", mem_req_valid, exp_req);
      check("mon_addr", mem_addr, exp_addr);
      check("mon_inst_valid", inst_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("mon_inst_pc", inst_pc, mq[0].pc);
        check("mon_inst", inst, mq[0].data);
      end
      check("mon_credits", (pend.size() + mq.size()) <= DEPTH, 1);
      if (redirect_valid) begin
        mq.delete();
        exp_addr  = word_align(redirect_pc);
        have_last = 1'b0;
        epoch++;
        if (rsp_now) void'(pend.pop_front());
      end else begin
        if (inst_valid && inst_ready) begin
          if (have_last) check("mon_pc_step", inst_pc, last_pc + 32'd4);
          last_pc   = inst_pc;
          have_last = 1'b1;
          if (mq.size() != 0) void'(mq.pop_front());
        end
        if (rsp_now) begin
          r = pend.pop_front();
          if (r.epoch == epoch) mq.push_back('{pc: r.pc, data: r.addr});
        end
        if (mem_req_valid && mem_req_ready) begin
          pend.push_back('{pc: exp_addr, addr: mem_addr, epoch: epoch, due: cyc + lat});
          exp_addr = exp_addr + 32'd4;
          hs_total++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int   hs0;
    int   n;
    logic seen;

    rst_n = 1'b0; mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (3) tick();
    #1;
    check("rst_addr", mem_addr, RPC);
    check("rst_req_valid", mem_req_valid, 1);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);

    // Reset release with a 1-cycle memory.
    tick(); rst_n = 1'b1; #1;
    check("t1_addr_c0", mem_addr, RPC);
    check("t1_valid_c0", inst_valid, 0);
    tick(); #1;
    check("t1_valid_c1", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t1_valid", inst_valid, 1);
      check("t1_pc", inst_pc, RPC + 32'(4 * i));
    end

    // Decode stalled: the queue fills and requests stop.
    tick(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; hs0 = hs_total;
    tick(); redirect_valid = 1'b0;
    repeat (9) tick();
    #1;
    check("t2_handshakes", hs_total - hs0, 4);
    check("t2_req_valid", mem_req_valid, 0);
    check("t2_head_pc", inst_pc, 32'h0000_1000);
    inst_ready = 1'b1;
    repeat (12) tick();

    // 3-cycle memory: redirect squashes two in-flight fetches.
    lat = 3; mem_req_ready = 1'b0;
    repeat (8) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; mem_req_ready = 1'b1;
    tick(); redirect_valid = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    check("t3_in_flight", pend.size(), 2);
    tick(); redirect_valid = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      tick(); #1; n++;
      if (inst_valid) seen = 1'b1;
    end
    check("t3_seen", seen, 1);
    check("t3_latency", n, 4);
    check("t3_pc", inst_pc, 32'h0000_0100);
    check("t3_inst", inst, 32'h0000_0100);

    // Redirect coinciding with a response and a pop, unaligned target.
    lat = 1;
    repeat (10) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; #1;
    check("t4_pre_valid", inst_valid, 1);
    check("t4_no_req", mem_req_valid, 0);
    tick(); redirect_valid = 1'b0; #1;
    check("t4_empty", inst_valid, 0);
    check("t4_addr", mem_addr, 32'h0000_0200);
    check("t4_req", mem_req_valid, 1);
    tick();
    tick(); #1;
    check("t4_first_valid", inst_valid, 1);
    check("t4_first_pc", inst_pc, 32'h0000_0200);

    // Random request and decode backpressure on a 2-cycle memory.
    lat = 2;
    repeat (100) begin
      tick();
      mem_req_ready = 1'($urandom_range(0, 1));
      inst_ready    = 1'($urandom_range(0, 1));
    end
    lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (8) tick();

    // Asynchronous reset with three buffered instructions.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_4000; inst_ready = 1'b0;
    tick(); redirect_valid = 1'b0;
    tick();
    tick();
    tick(); mem_req_ready = 1'b0;
    tick(); #1;
    check("t6_pre_valid", inst_valid, 1);
    check("t6_count", mq.size(), 3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", inst_valid, 0);
    check("t6_async_pc", inst_pc, 0);
    repeat (2) tick();
    rst_n = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b1; #1;
    check("t6_addr", mem_addr, RPC);
    check("t6_req_valid", mem_req_valid, 1);
    tick();
    tick(); #1;
    check("t6_first_pc", inst_pc, RPC);
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller sitting between the PC/branch logic and the byte-addressed, little-endian 32-bit instruction memory port. It issues sequential word fetches and tracks in-order, possibly multi-cycle memory responses. Returned words are buffered with their PCs in a small prefetch queue and delivered to decode over a valid/ready handshake. On a redirect (branch/jump) it flushes the queue and squashes responses still in flight.

## Interface
- DEPTH, 4: prefetch queue entries; also the maximum number of fetches in flight plus buffered; power of two, ≥2.
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- redirect_valid  in  1  a new fetch stream begins at redirect_pc this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- mem_req_valid  out  1  fetch request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  word-aligned fetch address.
- mem_rsp_valid  in  1  one response, in request order, no backpressure.
- mem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst  out  32  head instruction.
- inst_pc  out  32  head PC.

## Operation
- Registers:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next accepted response.
  - in_flight: issued requests not yet responded to, including squashed ones.
  - discard: in-flight responses to drop.
  - Prefetch queue: count 0..DEPTH.
- Issue:
  - mem_req_valid = !redirect_valid && (in_flight + count < DEPTH).
  - mem_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^32) and in_flight += 1.
- Response:
  - Each mem_rsp_valid decrements in_flight.
  - If discard > 0, the word is dropped and discard decrements.
  - Otherwise {rsp_pc, mem_rsp_data} is pushed and rsp_pc += 4.
  - The credit rule guarantees queue space; overflow is impossible.
- Output:
  - inst_valid = count != 0; inst/inst_pc = head.
  - The head pops on inst_valid && inst_ready.
- Redirect (priority over everything in that cycle):
  - Queue cleared; any same-cycle pop or push is void.
  - fetch_pc and rsp_pc are loaded with {redirect_pc[31:2], 2'b00}.
  - discard = in_flight − mem_rsp_valid, so a response arriving in the redirect cycle is itself dropped.
  - No request is issued that cycle.
- Counters in_flight and discard are $clog2(DEPTH+1) bits. Invariants: discard ≤ in_flight and in_flight + count ≤ DEPTH.

## Timing
- Reset values:
  - mem_req_valid = 1 (combinational from credits) and mem_addr = RESET_PC.
  - inst_valid = 0, inst = 0, inst_pc = 0.
  - in_flight = discard = count = 0.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Latency: a response accepted in cycle N gives inst_valid in cycle N+1 (registered queue, no bypass).
- Redirect in cycle N: the first request to the new target is in cycle N+1; the queue is empty in cycle N+1.
- With a 1-cycle memory and inst_ready held high, throughput is one instruction per cycle.
- Simultaneous push and pop at count = DEPTH is not reachable. Push and pop at any other count leaves count unchanged.

## Structure
- Package fetch_pkg:
  - RESET_PC default constant.
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] inst;}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries, with push, pop and a flush input (flush dominates). Counters and the issue/discard logic live in fetch_ctrl.

## Test plan
- Reset release, memory 1-cycle latency, data = address: first mem_addr = 0xBFC00000. inst_valid stays 0 until cycle 2, then inst_pc = 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles.
- inst_ready = 0: exactly 4 handshakes occur, then mem_req_valid = 0 and count = 4. Raising inst_ready resumes one request per pop, with no PC skipped or duplicated.
- 3-cycle memory latency: redirect to 0x00000100 with 2 requests in flight. Those 2 responses are dropped, and the next inst_pc is 0x00000100 with inst = 0x00000100.
- Redirect coincident with a mem_rsp_valid and an inst pop, to 0x00000203:
  - The arriving word is discarded and the queue is empty next cycle.
  - The next mem_addr is 0x00000200.
- mem_req_ready toggling randomly: the delivered inst_pc sequence is strictly +4 with no gaps, and in_flight + count never exceeds 4.
- rst_n asserted mid-stream with count = 3: inst_valid drops asynchronously. After release, the first mem_addr = 0xBFC00000.
